// File: rtl/sha1_stream_core.sv
// SHA-1 compression core with a streaming beat interface.
// Pre-padded 512-bit blocks arrive as 32- or 64-bit beats. Each block is
// compressed at UNROLL rounds per clock, and the result is chained into H.
module sha1_stream_core #(
  parameter int IN_W   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_first,
  output logic [159:0]    digest,
  output logic            digest_valid,
  output logic            busy,
  output logic            err
);

  localparam int BEATS = 512 / IN_W;
  localparam int WPB   = IN_W / 32;
  localparam logic [159:0] H_INIT = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [31:0] K0 = 32'h5a827999;
  localparam logic [31:0] K1 = 32'h6ed9eba1;
  localparam logic [31:0] K2 = 32'h8f1bbcdc;
  localparam logic [31:0] K3 = 32'hca62c1d6;

  typedef enum logic [1:0] {LOAD, ROUND, FINAL} state_t;

  state_t      state, state_next;
  logic [31:0] w [16];
  logic [31:0] a, b, c, d, e;
  logic [31:0] h [5];
  logic [31:0] h_sum [5];
  logic [31:0] base [5];
  logic [3:0]  beat_cnt;
  logic [6:0]  round_cnt;
  logic        chained;
  logic        use_init;
  logic        last_beat;
  logic        last_round;

  logic [31:0] rw [16];
  logic [31:0] ra, rb, rc, rd, re;
  logic [31:0] rf, rk, rtmp, rnew;
  logic [6:0]  rt;

  assign last_beat  = (beat_cnt == 4'(BEATS - 1));
  assign last_round = (round_cnt == 7'(80 - UNROLL));
  assign use_init   = in_first || !chained;

  // State register for the load / round / final sequence
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_next = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (last_round) state_next = FINAL;
      end
      FINAL: begin
        busy       = 1'b1;
        state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Starting chaining value: the standard initial H, or the stored H
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      base[i]  = use_init ? H_INIT[159-32*i -: 32] : h[i];
      h_sum[i] = h[i];
    end
    h_sum[0] = h[0] + a;
    h_sum[1] = h[1] + b;
    h_sum[2] = h[2] + c;
    h_sum[3] = h[3] + d;
    h_sum[4] = h[4] + e;
  end

  // UNROLL chained SHA-1 rounds; the window shifts so rw[0] is always W[t]
  always_comb begin
    rw   = w;
    ra   = a;
    rb   = b;
    rc   = c;
    rd   = d;
    re   = e;
    rf   = '0;
    rk   = '0;
    rtmp = '0;
    rnew = '0;
    rt   = '0;
    for (int u = 0; u < UNROLL; u++) begin
      rt = round_cnt + 7'(u);
      if (rt < 7'd20) begin
        rf = (rb & rc) | (~rb & rd);
        rk = K0;
      end else if (rt < 7'd40) begin
        rf = rb ^ rc ^ rd;
        rk = K1;
      end else if (rt < 7'd60) begin
        rf = (rb & rc) | (rb & rd) | (rc & rd);
        rk = K2;
      end else begin
        rf = rb ^ rc ^ rd;
        rk = K3;
      end
      rtmp = {ra[26:0], ra[31:27]} + rf + re + rk + rw[0];
      re   = rd;
      rd   = rc;
      rc   = {rb[1:0], rb[31:2]};
      rb   = ra;
      ra   = rtmp;
      rnew = rw[13] ^ rw[8] ^ rw[2] ^ rw[0];
      for (int i = 0; i < 15; i++) rw[i] = rw[i+1];
      rw[15] = {rnew[30:0], rnew[31]};
    end
  end

  // Datapath: beat capture, round updates, final chaining and error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 5; i++) h[i] <= '0;
      a            <= '0;
      b            <= '0;
      c            <= '0;
      d            <= '0;
      e            <= '0;
      beat_cnt     <= '0;
      round_cnt    <= '0;
      chained      <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            for (int k = 0; k < WPB; k++)
              w[4'(int'(beat_cnt) * WPB + k)] <= in_data[IN_W-1-32*k -: 32];
            if (beat_cnt == 4'd0) begin
              digest_valid <= 1'b0;
              a <= base[0];
              b <= base[1];
              c <= base[2];
              d <= base[3];
              e <= base[4];
              for (int i = 0; i < 5; i++) h[i] <= base[i];
              if (in_first)      err <= 1'b0;
              else if (!chained) err <= 1'b1;
            end
            beat_cnt  <= last_beat ? 4'd0 : beat_cnt + 4'd1;
            round_cnt <= '0;
          end
        end
        ROUND: begin
          w         <= rw;
          a         <= ra;
          b         <= rb;
          c         <= rc;
          d         <= rd;
          e         <= re;
          round_cnt <= last_round ? 7'd0 : round_cnt + 7'(UNROLL);
        end
        FINAL: begin
          for (int i = 0; i < 5; i++) h[i] <= h_sum[i];
          digest       <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4]};
          digest_valid <= 1'b1;
          chained      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
